// File: rtl/hc_rd_stream_engine.sv
// ============================================================================
// hc_rd_stream_engine : credit-limited CCI-P c0 multi-line read engine with a
// show-ahead response FIFO.  Optional HC_RD_PERF_EN adds perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hc_rd_stream_engine #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 42,
  parameter int DATA_W     = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_lines,
  input  logic              c0_almfull,
  output logic              c0_req_valid,
  output logic [ADDR_W-1:0] c0_req_addr,
  output logic [15:0]       c0_req_mdata,
  input  logic              c0_rsp_valid,
  input  logic              c0_rsp_rdline,
  input  logic [15:0]       c0_rsp_mdata,
  input  logic [DATA_W-1:0] c0_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef HC_RD_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       num_q, issued, accepted, delivered;
  logic [PTR_W:0]    fifo_count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W+15:0] mem [FIFO_DEPTH];

  logic        start_ok, issue, push, pop;
  logic [32:0] credit_used;

  assign start_ok = (state == S_IDLE) && start;
  // Outstanding reads plus buffered lines can never exceed the FIFO size.
  assign credit_used = {1'b0, issued - accepted} + 33'(fifo_count);
  assign issue = (state == S_RUN) && (issued < num_q) && !c0_almfull &&
                 (credit_used < 33'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop  = out_valid && out_ready;
  assign push = c0_rsp_valid && c0_rsp_rdline && (state != S_IDLE) &&
                ((fifo_count != (PTR_W+1)'(FIFO_DEPTH)) || pop);

  assign {out_idx, out_data} = mem[rd_ptr];
  assign out_last = out_valid && (delivered == num_q - 32'd1);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_lines == 32'd0) ? S_DONE : S_RUN;
      S_RUN:   if (issued == num_q) state_nxt = S_DRAIN;
      S_DRAIN: if ((delivered == num_q) || (pop && out_last)) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issued       <= '0;
      accepted     <= '0;
      delivered    <= '0;
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      state        <= state_nxt;
      c0_req_valid <= issue;
      if (start_ok) begin
        base_q    <= base_addr;
        num_q     <= num_lines;
        issued    <= '0;
        accepted  <= '0;
        delivered <= '0;
      end else begin
        if (issue) issued    <= issued + 32'd1;
        if (push)  accepted  <= accepted + 32'd1;
        if (pop)   delivered <= delivered + 32'd1;
      end
      if (issue) begin
        c0_req_addr  <= base_q + ADDR_W'(issued);
        c0_req_mdata <= issued[15:0];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {c0_rsp_mdata, c0_rsp_data};
  end

`ifdef HC_RD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if ((state == S_RUN) && (issued < num_q) && c0_almfull && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hc_rd_stream_engine.sv
// Directed self-checking bench for hc_rd_stream_engine (default build).
`default_nettype none

module tb_hc_rd_stream_engine;
  localparam int AW = 42;
  localparam int DW = 512;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   num_lines = '0;
  logic          c0_almfull = 1'b0;
  logic          c0_req_valid;
  logic [AW-1:0] c0_req_addr;
  logic [15:0]   c0_req_mdata;
  logic          c0_rsp_valid = 1'b0, c0_rsp_rdline = 1'b0;
  logic [15:0]   c0_rsp_mdata = '0;
  logic [DW-1:0] c0_rsp_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [15:0]   out_idx;
  logic          out_last, busy, done;

  hc_rd_stream_engine #(.FIFO_DEPTH(64), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .c0_almfull(c0_almfull), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_rdline(c0_rsp_rdline),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int req_cnt, beat_cnt, done_cnt, last_cnt, last_pos, valid_cycles;
  logic [AW-1:0] exp_base;
  int idx_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] rsp_m;
  bit auto_rsp = 1'b0;

  function automatic logic [DW-1:0] line_data(input logic [15:0] idx);
    return {32{idx ^ 16'h5A3C}};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [31:0] num);
    exp_base = base; req_cnt = 0; beat_cnt = 0; done_cnt = 0;
    last_cnt = 0; last_pos = -1; valid_cycles = 0;
    idx_q.delete(); pend_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_lines = num;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("done_seen", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k = 0;
    while (req_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("req_wait", 64'(req_cnt >= n), 64'd1);
  endtask

  task automatic send_rsp(input logic [15:0] m, input bit rd);
    @(posedge clk); #1;
    c0_rsp_valid = 1'b1; c0_rsp_rdline = rd; c0_rsp_mdata = m; c0_rsp_data = line_data(m);
  endtask

  task automatic rsp_idle();
    @(posedge clk); #1;
    c0_rsp_valid = 1'b0; c0_rsp_rdline = 1'b0;
  endtask

  // Observer: requests, delivered beats and done pulses, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (c0_req_valid) begin
        check("req_addr", 64'(c0_req_addr), 64'(AW'(exp_base + AW'(req_cnt))));
        check("req_mdata", 64'(c0_req_mdata), 64'(req_cnt[15:0]));
        pend_q.push_back(c0_req_mdata);
        req_cnt++;
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        check("out_data", 64'(out_data == line_data(out_idx)), 64'd1);
        idx_q.push_back(int'(out_idx));
        if (out_last) begin
          last_cnt++;
          last_pos = beat_cnt;
        end
        beat_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // In-order host model, one response per cycle.
  initial forever begin
    @(posedge clk); #1;
    if (auto_rsp) begin
      if (pend_q.size() > 0) begin
        rsp_m = pend_q.pop_front();
        c0_rsp_valid = 1'b1; c0_rsp_rdline = 1'b1;
        c0_rsp_mdata = rsp_m; c0_rsp_data = line_data(rsp_m);
      end else begin
        c0_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    tick(3);
    @(negedge clk);
    check("rst_req_valid", 64'(c0_req_valid), 64'd0);
    check("rst_req_addr", 64'(c0_req_addr), 64'd0);
    check("rst_req_mdata", 64'(c0_req_mdata), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Single line: busy one cycle after start, request the cycle after that.
    auto_rsp = 1'b1; out_ready = 1'b1;
    do_start(42'h1000, 32'd1);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_req_early", 64'(c0_req_valid), 64'd0);
    @(negedge clk);
    check("t1_req_valid", 64'(c0_req_valid), 64'd1);
    check("t1_req_addr", 64'(c0_req_addr), 64'h1000);
    check("t1_req_mdata", 64'(c0_req_mdata), 64'd0);
    wait_done(50);
    tick(2);
    check("t1_beats", 64'(beat_cnt), 64'd1);
    check("t1_last", 64'(last_cnt), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // Zero lines: straight to DONE.
    do_start(42'h5000, 32'd0);
    @(negedge clk);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t2_busy_off", 64'(busy), 64'd0);
    check("t2_done_off", 64'(done), 64'd0);
    tick(3);
    check("t2_reqs", 64'(req_cnt), 64'd0);
    check("t2_valid", 64'(valid_cycles), 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure: credit stops issue at FIFO depth.
    out_ready = 1'b0;
    do_start(42'h40000, 32'd200);
    tick(200);
    check("t3_stall_reqs", 64'(req_cnt), 64'd64);
    check("t3_out_valid", 64'(out_valid), 64'd1);
    check("t3_out_last", 64'(out_last), 64'd0);
    check("t3_beats0", 64'(beat_cnt), 64'd0);
    out_ready = 1'b1;
    wait_done(2000);
    check("t3_beats", 64'(beat_cnt), 64'd200);
    check("t3_reqs", 64'(req_cnt), 64'd200);
    check("t3_last_cnt", 64'(last_cnt), 64'd1);
    check("t3_last_pos", 64'(last_pos), 64'd199);
    err = 0;
    foreach (idx_q[i]) if (idx_q[i] != i) err++;
    check("t3_idx_err", 64'(err), 64'd0);
    tick(2);

    // Almost-full hold, with the address space wrapping mid-run.
    do_start(42'h3FF_FFFF_FFF8, 32'd30);
    wait_reqs(5, 100);
    c0_almfull = 1'b1;
    tick(1);
    err = req_cnt;
    tick(9);
    check("t4_hold", 64'(req_cnt), 64'(err));
    check("t4_partial", 64'(req_cnt < 30), 64'd1);
    c0_almfull = 1'b0;
    wait_done(500);
    check("t4_reqs", 64'(req_cnt), 64'd30);
    check("t4_beats", 64'(beat_cnt), 64'd30);
    tick(2);

    // Reversed responses with non-RDLINE traffic interleaved.
    auto_rsp = 1'b0;
    do_start(42'h2000, 32'd4);
    wait_reqs(4, 50);
    tick(2);
    send_rsp(16'd3, 1'b1);
    send_rsp(16'd7, 1'b0);
    send_rsp(16'd2, 1'b1);
    send_rsp(16'd1, 1'b1);
    send_rsp(16'd5, 1'b0);
    send_rsp(16'd0, 1'b1);
    rsp_idle();
    wait_done(100);
    check("t5_beats", 64'(beat_cnt), 64'd4);
    if (idx_q.size() == 4) begin
      check("t5_idx0", 64'(idx_q[0]), 64'd3);
      check("t5_idx1", 64'(idx_q[1]), 64'd2);
      check("t5_idx2", 64'(idx_q[2]), 64'd1);
      check("t5_idx3", 64'(idx_q[3]), 64'd0);
    end
    check("t5_last_pos", 64'(last_pos), 64'd3);
    tick(2);

    // Reset with reads in flight; late responses must be dropped.
    out_ready = 1'b0;
    do_start(42'h8000, 32'd10);
    wait_reqs(5, 50);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("t6_req_valid", 64'(c0_req_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_last", 64'(out_last), 64'd0);
    valid_cycles = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) send_rsp(16'(i), 1'b1);
    rsp_idle();
    out_ready = 1'b1;
    tick(5);
    check("t6_late_valid", 64'(valid_cycles), 64'd0);
    check("t6_late_busy", 64'(busy), 64'd0);
    check("t6_late_done", 64'(done_cnt), 64'd0);

    // Fresh run after abort sees no stale FIFO entries.
    auto_rsp = 1'b1;
    do_start(42'h100, 32'd2);
    wait_done(100);
    check("t7_beats", 64'(beat_cnt), 64'd2);
    if (idx_q.size() == 2) begin
      check("t7_idx0", 64'(idx_q[0]), 64'd0);
      check("t7_idx1", 64'(idx_q[1]), 64'd1);
    end
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
